// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - ISA constants and fetch state encoding shared by the fetch unit
// Purpose: one-hot instruction group masks, group-0 control-flow opcode indices,
//          the alternate RET encoding, program address width and fetch FSM states.
// Ports:   none (package).
package cpu_isa_pkg;

  localparam int ADDR_W = 12;

  // One-hot group bits in IR[23:19]
  localparam logic [23:0] GRP0 = 24'h800000;
  localparam logic [23:0] GRP1 = 24'h400000;
  localparam logic [23:0] GRP2 = 24'h200000;
  localparam logic [23:0] GRP3 = 24'h100000;
  localparam logic [23:0] GRP4 = 24'h080000;

  // Group-0 opcode indices, taken from IR[19:12]
  localparam logic [7:0] OP_JMP = 8'd0;
  localparam logic [7:0] OP_JZE = 8'd1;
  localparam logic [7:0] OP_JNE = 8'd2;
  localparam logic [7:0] OP_JCY = 8'd3;
  localparam logic [7:0] OP_RET = 8'd4;
  localparam logic [7:0] OP_BSR = 8'd5;

  // Second encoding of RET that lives outside group 0
  localparam logic [23:0] RET4 = 24'h080005;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    ISSUE
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - program memory and IR handshake bundle
// Purpose: groups the program-memory read port and the IR issue handshake.
// Ports (signals):
//   pc_addr   fetch -> mem   program memory address
//   mem_req   fetch -> mem   one-cycle read request
//   mem_valid mem -> fetch   mem_data valid this cycle
//   mem_data  mem -> fetch   fetched instruction word
//   IR        fetch -> dec   registered instruction word
//   ir_valid  fetch -> dec   IR holds a new instruction
//   ir_ready  dec -> fetch   decoder accepts IR
// Modports: master = fetch unit, slave = memory/decoder side.
interface instruction_fetch_if #(
  parameter int ADDR_W = cpu_isa_pkg::ADDR_W
) ();

  logic [ADDR_W-1:0] pc_addr;
  logic              mem_req;
  logic              mem_valid;
  logic [23:0]       mem_data;
  logic [23:0]       IR;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output pc_addr, mem_req, IR, ir_valid,
    input  mem_valid, mem_data, ir_ready
  );

  modport slave (
    input  pc_addr, mem_req, IR, ir_valid,
    output mem_valid, mem_data, ir_ready
  );

endinterface

// File: rtl/return_stack.sv
// rtl/return_stack.sv - synchronous LIFO holding subroutine return addresses
// Purpose: push/pop stack; dout always shows the top entry when not empty.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears pointer only)
//   push_i, pop_i   one operation per cycle; ignored when full / empty
//   din_i           value pushed
//   dout_o          current top of stack
//   full_o, empty_o pointer at DEPTH / at zero
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0] wr_idx, top_idx;
  logic             do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == '0);

  // Push takes priority if a caller ever asserts both.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !push_i && !empty_o;

  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - 1'b1);
  assign dout_o  = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + 1'b1;
    end else if (do_pop) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries need no reset: they are only read below the pointer.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, fetch FSM and branch resolution feeding the decoder IR
// Purpose: fetches a word per instruction over mem_req/mem_valid, presents it as IR with
//          ir_valid/ir_ready, and resolves JMP/JZE/JNE/JCY/BSR/RET with a return stack.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   bus (master)           program memory port and IR handshake
//   zero_flag, carry_flag  ALU flags, sampled in the IR handshake cycle
//   stack_err              sticky: BSR with full stack or RET with empty stack
module instruction_fetch import cpu_isa_pkg::*; #(
  parameter int                ADDR_W      = cpu_isa_pkg::ADDR_W,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus,
  input  logic                zero_flag,
  input  logic                carry_flag,
  output logic                stack_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [23:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              stack_err_q, stack_err_d;

  logic [ADDR_W-1:0] pc_inc, tgt, next_pc, stk_dout;
  logic [4:0]        grp;
  logic [7:0]        idx;
  logic              is_grp0, is_jmp, is_jze, is_jne, is_jcy, is_bsr, is_ret;
  logic              handshake, push, pop, stk_full, stk_empty, mem_req;

  // Decode of the held IR word
  assign grp     = ir_q[23:19];
  assign idx     = ir_q[19:12];
  assign tgt     = ADDR_W'(ir_q[11:0]);
  assign is_grp0 = (grp == GRP0[23:19]);
  assign is_jmp  = is_grp0 && (idx == OP_JMP);
  assign is_jze  = is_grp0 && (idx == OP_JZE);
  assign is_jne  = is_grp0 && (idx == OP_JNE);
  assign is_jcy  = is_grp0 && (idx == OP_JCY);
  assign is_bsr  = is_grp0 && (idx == OP_BSR);
  assign is_ret  = (is_grp0 && (idx == OP_RET)) || (ir_q == RET4);

  assign pc_inc    = pc_q + 1'b1;
  assign handshake = (state_q == ISSUE) && ir_valid_q && bus.ir_ready;

  // Branch target; failed BSR/RET fall through to pc+1.
  always_comb begin
    next_pc = pc_inc;
    if (is_jmp) begin
      next_pc = tgt;
    end else if (is_jze && zero_flag) begin
      next_pc = tgt;
    end else if (is_jne && !zero_flag) begin
      next_pc = tgt;
    end else if (is_jcy && carry_flag) begin
      next_pc = tgt;
    end else if (is_bsr && !stk_full) begin
      next_pc = tgt;
    end else if (is_ret && !stk_empty) begin
      next_pc = stk_dout;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    stack_err_d = stack_err_q;
    push        = 1'b0;
    pop         = 1'b0;
    mem_req     = 1'b0;
    case (state_q)
      FETCH: begin
        // Gated so no request escapes while reset is held.
        mem_req = !reset;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_valid) begin
          ir_d       = bus.mem_data;
          ir_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          ir_valid_d = 1'b0;
          pc_d       = next_pc;
          push       = is_bsr && !stk_full;
          pop        = is_ret && !stk_empty;
          if ((is_bsr && stk_full) || (is_ret && stk_empty)) begin
            stack_err_d = 1'b1;
          end
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      stack_err_q <= stack_err_d;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .dout_o  (stk_dout),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign bus.pc_addr  = pc_q;
  assign bus.mem_req  = mem_req;
  assign bus.IR       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign stack_err    = stack_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;
  import cpu_isa_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zero_flag = 1'b0;
  logic carry_flag = 1'b0;
  logic stack_err;

  logic        resp_en = 1'b1;
  logic        auto_valid = 1'b0;
  logic [23:0] auto_data = '0;
  logic        man_valid = 1'b0;
  logic [23:0] man_data = '0;
  logic        ready = 1'b0;

  logic [23:0] prog [0:4095];

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_if bus ();

  assign bus.mem_valid = auto_valid | man_valid;
  assign bus.mem_data  = man_valid ? man_data : auto_data;
  assign bus.ir_ready  = ready;

  instruction_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Program memory: answers each request with valid in the following cycle.
  initial begin
    logic [11:0] req_addr;
    forever begin
      @(negedge clk);
      if (resp_en && bus.mem_req) begin
        req_addr = bus.pc_addr;
        @(posedge clk);
        #1;
        auto_valid = 1'b1;
        auto_data  = prog[req_addr];
        @(posedge clk);
        #1;
        auto_valid = 1'b0;
      end
    end
  end

  task automatic wait_req(input string tag, output logic [11:0] addr);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req seen"}, 32'(bus.mem_req), 32'd1);
    addr = bus.pc_addr;
  endtask

  task automatic wait_issue(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ir_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ir_valid"}, 32'(bus.ir_valid), 32'd1);
  endtask

  task automatic accept();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  task automatic run_insn(input string tag, input logic [11:0] exp_pc, input logic z, input logic c);
    logic [11:0] a;
    wait_req(tag, a);
    check({tag, " pc_addr"}, 32'(a), 32'(exp_pc));
    wait_issue(tag);
    check({tag, " IR"}, 32'(bus.IR), 32'(prog[exp_pc]));
    zero_flag  = z;
    carry_flag = c;
    accept();
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
  endtask

  initial begin
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) prog[i] = 24'h000000;
    prog[12'h000] = 24'h200000;
    prog[12'h001] = 24'h800123;  // JMP 0x123
    prog[12'h123] = 24'h800010;  // JMP 0x010
    prog[12'h010] = 24'h801050;  // JZE 0x050
    prog[12'h011] = 24'h800010;  // JMP 0x010
    prog[12'h050] = 24'h802060;  // JNE 0x060
    prog[12'h051] = 24'h803070;  // JCY 0x070
    prog[12'h070] = 24'h8000FF;  // JMP 0x0FF
    prog[12'h0FF] = 24'h805200;  // BSR 0x200
    prog[12'h200] = 24'h804000;  // RET
    prog[12'h100] = 24'h805300;  // BSR 0x300
    prog[12'h300] = 24'h080005;  // RET (alternate encoding)
    prog[12'h101] = 24'h800FFF;  // JMP 0xFFF
    prog[12'hFFF] = 24'h804000;  // RET on empty stack

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst pc_addr", 32'(bus.pc_addr), 32'h000);
    check("rst ir_valid", 32'(bus.ir_valid), 32'd0);
    check("rst IR", 32'(bus.IR), 32'h000000);
    check("rst stack_err", 32'(stack_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Test 1: single request pulse, IR valid two cycles after reset release
    @(negedge clk);
    check("t1 mem_req", 32'(bus.mem_req), 32'd1);
    check("t1 pc_addr", 32'(bus.pc_addr), 32'h000);
    @(negedge clk);
    check("t1 req one cycle", 32'(bus.mem_req), 32'd0);
    check("t1 not yet valid", 32'(bus.ir_valid), 32'd0);
    @(negedge clk);
    check("t1 ir_valid", 32'(bus.ir_valid), 32'd1);
    check("t1 IR", 32'(bus.IR), 32'h200000);
    accept();

    // Test 2/3: jumps and conditional branches
    run_insn("t2 jmp", 12'h001, 1'b0, 1'b0);
    run_insn("t2 tgt", 12'h123, 1'b0, 1'b0);
    run_insn("t3 jze z0", 12'h010, 1'b0, 1'b0);
    run_insn("t3 fallthru", 12'h011, 1'b0, 1'b0);
    run_insn("t3 jze z1", 12'h010, 1'b1, 1'b0);
    run_insn("jne z1", 12'h050, 1'b1, 1'b0);
    run_insn("jcy c1", 12'h051, 1'b0, 1'b1);
    run_insn("jmp 0ff", 12'h070, 1'b0, 1'b0);

    // Test 4: subroutine call and both RET encodings
    run_insn("t4 bsr", 12'h0FF, 1'b0, 1'b0);
    check("t4 sp after bsr", 32'(dut.u_stack.sp_q), 32'd1);
    run_insn("t4 ret", 12'h200, 1'b0, 1'b0);
    check("t4 sp after ret", 32'(dut.u_stack.sp_q), 32'd0);
    run_insn("bsr2", 12'h100, 1'b0, 1'b0);
    run_insn("ret4", 12'h300, 1'b0, 1'b0);
    check("ret4 sp", 32'(dut.u_stack.sp_q), 32'd0);
    run_insn("jmp fff", 12'h101, 1'b0, 1'b0);

    // Test 5: RET on empty stack wraps pc+1 to 0
    check("t5 err before", 32'(stack_err), 32'd0);
    run_insn("t5 ret empty", 12'hFFF, 1'b0, 1'b0);
    check("t5 stack_err", 32'(stack_err), 32'd1);
    check("t5 sp", 32'(dut.u_stack.sp_q), 32'd0);
    wait_req("t5 wrap", a);
    check("t5 wrap pc", 32'(a), 32'h000);
    wait_issue("t5 wrap");

    // Reset while an IR is pending, then fill the stack
    reset = 1'b1;
    for (int i = 0; i < 8; i++) prog[i] = 24'h805000 | 24'(i + 1);
    prog[8] = 24'h805400;
    prog[9] = 24'h400ABC;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst2 stack_err", 32'(stack_err), 32'd0);
    check("rst2 sp", 32'(dut.u_stack.sp_q), 32'd0);
    for (int i = 0; i < 8; i++) run_insn("t5 bsr fill", 12'(i), 1'b0, 1'b0);
    check("t5 sp full", 32'(dut.u_stack.sp_q), 32'd8);
    check("t5 no err at 8", 32'(stack_err), 32'd0);
    run_insn("t5 bsr9", 12'h008, 1'b0, 1'b0);
    check("t5 err on full", 32'(stack_err), 32'd1);
    check("t5 sp stays 8", 32'(dut.u_stack.sp_q), 32'd8);

    // Test 6: stall, the failed BSR fell through to 0x009
    wait_req("t6", a);
    check("t6 bsr9 fallthru", 32'(a), 32'h009);
    wait_issue("t6");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6 stall IR", 32'(bus.IR), 32'h400ABC);
      check("t6 stall valid", 32'(bus.ir_valid), 32'd1);
    end
    resp_en = 1'b0;
    accept();
    wait_req("t6 next", a);
    check("t6 next pc", 32'(a), 32'h00A);
    @(negedge clk);
    check("t6 in wait", 32'(bus.mem_req), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    man_valid = 1'b1;
    man_data  = 24'h800777;
    @(negedge clk);
    check("t6 rst pc_addr", 32'(bus.pc_addr), 32'h000);
    check("t6 rst mem_req", 32'(bus.mem_req), 32'd0);
    check("t6 rst ir_valid", 32'(bus.ir_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    man_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6 late valid ignored", 32'(bus.ir_valid), 32'd0);
      check("t6 IR reset", 32'(bus.IR), 32'h000000);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
